dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences the data-memory access for the instruction currently in the MEM stage, i.e. the contents of the EX/MEM pipeline register.
- Drives a request/ready handshake toward data memory and holds a global pipeline stall while the access is outstanding.
- Returns load data to MEM/WB and flags bus timeouts.
- Sits between the EX/MEM register outputs and the data memory; its stall output freezes IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
DATA_W, 32, data bus width
ADDR_W, 32, address width
TIMEOUT, 16, max cycles in REQ before bus error (legal range 2..255)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_read_m  in  1  MEM-stage load (from MEM_M control bits)
mem_write_m  in  1  MEM-stage store (from MEM_M control bits)
addr_m  in  ADDR_W  effective address (ALUOut_M)
wdata_m  in  DATA_W  store data (WriteData_M)
dmem_req  out  1  memory request, held until accepted
dmem_we  out  1  1 = write, 0 = read; valid while dmem_req
dmem_addr  out  ADDR_W  registered address
dmem_wdata  out  DATA_W  registered store data
dmem_ready  in  1  memory completion, sampled only while dmem_req = 1
dmem_rdata  in  DATA_W  read data, valid with dmem_ready
stall  out  1  freeze all pipeline registers
rdata_m  out  DATA_W  load result to MEM/WB
rdata_valid  out  1  one-cycle pulse: rdata_m holds a new load result
bus_error  out  1  one-cycle pulse on timeout
misalign  out  1  one-cycle pulse on misaligned access (constant 0 when the feature is off)

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, counter = 0.
  - All outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, rdata_m, rdata_valid, bus_error, misalign.
  - stall is combinational and evaluates to 0, because reset forces IDLE.
- Access detection: access = mem_read_m | mem_write_m. When both are set, it is treated as a write.
- stall = (state == IDLE && access) | (state == REQ). stall is 0 in DONE, so the MEM instruction advances on the edge that leaves DONE.
- IDLE:
  - On access, latch addr_m, wdata_m and we = mem_write_m into the dmem_* registers.
  - Set dmem_req = 1, counter = 0, go to REQ.
  - Minimum added latency: one stall cycle plus the memory latency.
- REQ:
  - dmem_req, dmem_addr, dmem_wdata and dmem_we are held stable.
  - On dmem_ready = 1 with a read: rdata_m <= dmem_rdata, rdata_valid <= 1, drop dmem_req, go to DONE.
  - On dmem_ready = 1 with a write: drop dmem_req, go to DONE; rdata_m is unchanged.
  - Otherwise counter increments. When counter == TIMEOUT-1 and dmem_ready = 0: drop dmem_req, bus_error <= 1, rdata_m <= 0 if a read, go to DONE.
  - dmem_ready on the same cycle as the timeout: completion wins and no error is raised.
- DONE:
  - Lasts one cycle, stall = 0; rdata_valid and bus_error are asserted during this cycle only.
  - Always returns to IDLE; the next access is evaluated in IDLE on the following cycle.
  - Consequence: back-to-back memory instructions each pay at least one IDLE stall cycle.
- dmem_ready while dmem_req = 0 is ignored.
- Reset mid-REQ: dmem_req drops immediately (async). No completion or error is reported.
- Counter width = clog2(TIMEOUT); it wraps only by returning to 0 on entry to REQ.

Optional Feature:
Macro DMEM_MISALIGN_CHECK_EN.
- Defined:
  - In IDLE with access and addr_m[1:0] != 0, no request is issued.
  - misalign <= 1, rdata_m <= 0 if a read, go directly to DONE.
  - stall is 1 for that IDLE cycle only.
- Undefined: no alignment check is performed, and misalign is tied to 0.

Decomposition:
- Package dmem_ctrl_pkg contains:
  - the state enum (IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2);
  - the default DATA_W, ADDR_W and TIMEOUT constants;
  - a clog2 helper function.
- One sub-module, dmem_timeout_cnt: a clearable up-counter with a terminal-count flag, parameterised by TIMEOUT.

Test Plan:
- Load, memory ready after 3 cycles, addr 0x100, rdata 0xDEADBEEF:
  - stall high 4 cycles;
  - dmem_addr = 0x100 and dmem_we = 0 throughout REQ;
  - rdata_m = 0xDEADBEEF with a rdata_valid pulse in DONE.
- Store, addr 0x204, data 0x12345678, ready next cycle:
  - dmem_we = 1, dmem_wdata = 0x12345678;
  - stall high 2 cycles; no rdata_valid pulse.
- Load with dmem_ready never asserted, TIMEOUT = 16:
  - dmem_req drops after 16 REQ cycles;
  - one bus_error pulse, rdata_m = 0, pipeline resumes.
- dmem_ready asserted on the cycle counter == TIMEOUT-1: completes normally, bus_error stays 0.
- rst_n pulled low mid-REQ:
  - dmem_req and stall go to 0 within the same cycle, with no clock edge needed;
  - after release, a new load completes normally.
- With DMEM_MISALIGN_CHECK_EN, load at addr 0x102:
  - dmem_req never rises; misalign pulses; stall high for 1 cycle.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and defaults for the data-memory access controller.
// Optional misalignment check is enabled with DMEM_MISALIGN_CHECK_EN.
package dmem_ctrl_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_timeout_cnt.sv
// Clearable up-counter for REQ-phase cycles with a terminal-count flag at TIMEOUT-1.
module dmem_timeout_cnt
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int                CNT_W  = clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority, otherwise advance when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: request/ready handshake, pipeline stall, load return, timeout.
// Define DMEM_MISALIGN_CHECK_EN to reject accesses whose addr_m[1:0] is non-zero.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [DATA_W-1:0] wdata_m,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata_m,
    output logic              rdata_valid,
    output logic              bus_error,
    output logic              misalign
);

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                berr_q, berr_d;
    logic                mis_q, mis_d;

    logic                access_s;
    logic                misaligned_s;
    logic                cnt_clr_s;
    logic                cnt_en_s;
    logic                cnt_tc_s;

    assign access_s = mem_read_m | mem_write_m;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned_s = (addr_m[1:0] != 2'b00);
`else
    assign misaligned_s = 1'b0;
`endif

    // Stall covers the IDLE cycle that launches an access and every REQ cycle; DONE lets the pipeline move.
    assign stall = ((state_q == IDLE) && access_s) || (state_q == REQ);

    dmem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_s),
        .en_i  (cnt_en_s),
        .tc_o  (cnt_tc_s)
    );

    // Next-state and output-register logic for the access sequence.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        berr_d    = 1'b0;
        mis_d     = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_s && misaligned_s) begin
                    mis_d   = 1'b1;
                    state_d = DONE;
                    if (!mem_write_m) begin
                        rdata_d = {DATA_W{1'b0}};
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (access_s) begin
                    addr_d    = addr_m;
                    wdata_d   = wdata_m;
                    we_d      = mem_write_m;
                    req_d     = 1'b1;
                    cnt_clr_s = 1'b1;
                    state_d   = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // Completion is checked first so a ready on the terminal-count cycle wins over the timeout.
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d  = dmem_rdata;
                        rvalid_d = 1'b1;
                    end else begin
                        rdata_d  = rdata_q;
                    end
                end else if (cnt_tc_s) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = {DATA_W{1'b0}};
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_en_s = 1'b1;
                    state_d  = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            rdata_q  <= {DATA_W{1'b0}};
            rvalid_q <= 1'b0;
            berr_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            berr_q   <= berr_d;
            mis_q    <= mis_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign rdata_m     = rdata_q;
    assign rdata_valid = rvalid_q;
    assign bus_error   = berr_q;
    assign misalign    = mis_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed table, reset corner, randomized accesses vs. a per-access model.
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 16;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_read_m, mem_write_m;
    logic [31:0] addr_m, wdata_m;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] rdata_m;
    logic        rdata_valid, bus_error, misalign;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_rdata;

    dmem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .addr_m(addr_m), .wdata_m(wdata_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall), .rdata_m(rdata_m),
        .rdata_valid(rdata_valid), .bus_error(bus_error), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one MEM-stage access starting with the DUT idle; acts as the memory, answering on REQ cycle rdy_after.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input int rdy_after, input logic [31:0] rdat,
                             output int n_stall, output int n_req, output int n_rv, output int n_be,
                             output int n_mis, output logic [31:0] last_rdata, output int stable_ok,
                             output int finished);
        int req_idx;
        n_stall = 0; n_req = 0; n_rv = 0; n_be = 0; n_mis = 0;
        stable_ok = 1; finished = 0; req_idx = 0; last_rdata = 32'h0;
        mem_read_m = rd; mem_write_m = wr; addr_m = a; wdata_m = wd;
        for (int c = 0; c < 200; c++) begin
            #1;
            n_rv  += int'(rdata_valid);
            n_be  += int'(bus_error);
            n_mis += int'(misalign);
            if (!stall) begin
                finished   = 1;
                last_rdata = rdata_m;
                break;
            end
            n_stall++;
            if (dmem_req) begin
                n_req++;
                req_idx++;
                if (dmem_addr !== a || dmem_we !== wr || (wr && dmem_wdata !== wd)) stable_ok = 0;
                dmem_ready = (req_idx == rdy_after);
                dmem_rdata = (req_idx == rdy_after) ? rdat : $urandom;
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            @(negedge clk);
        end
        mem_read_m = 1'b0; mem_write_m = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        #1;
        n_rv  += int'(rdata_valid);
        n_be  += int'(bus_error);
        n_mis += int'(misalign);
        n_stall += int'(stall);
    endtask

    task automatic run_and_check(input string tag, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] wd, input int rdy,
                                 input logic [31:0] rdat, input int e_stall, input int e_req,
                                 input int e_rv, input int e_be, input int e_mis,
                                 input logic [31:0] e_rdata);
        int n_stall, n_req, n_rv, n_be, n_mis, stable_ok, finished;
        logic [31:0] last_rdata;
        do_access(rd, wr, a, wd, rdy, rdat, n_stall, n_req, n_rv, n_be, n_mis, last_rdata, stable_ok, finished);
        check({tag, ".finished"}, 32'(finished), 32'd1);
        check({tag, ".stall_cycles"}, 32'(n_stall), 32'(e_stall));
        check({tag, ".req_cycles"}, 32'(n_req), 32'(e_req));
        check({tag, ".rdata_valid"}, 32'(n_rv), 32'(e_rv));
        check({tag, ".bus_error"}, 32'(n_be), 32'(e_be));
        check({tag, ".misalign"}, 32'(n_mis), 32'(e_mis));
        check({tag, ".rdata_m"}, last_rdata, e_rdata);
        check({tag, ".req_stable"}, 32'(stable_ok), 32'd1);
    endtask

    // Reference rules for one access, computed from the handshake contract rather than the FSM.
    function automatic void model(input logic wr, input logic [31:0] a, input int rdy,
                                  input logic [31:0] rdat, inout logic [31:0] rmod,
                                  output int e_stall, output int e_req, output int e_rv,
                                  output int e_be, output int e_mis);
        bit mis, completes;
        mis       = MIS_EN && (a[1:0] != 2'b00);
        completes = !mis && (rdy >= 1) && (rdy <= TIMEOUT);
        e_mis     = int'(mis);
        e_req     = mis ? 0 : (completes ? rdy : TIMEOUT);
        e_stall   = 1 + e_req;
        e_rv      = int'(completes && !wr);
        e_be      = int'(!mis && !completes);
        if (!wr) rmod = completes ? rdat : 32'h0;
    endfunction

    typedef struct {
        string       tag;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rdy;
        logic [31:0] rdata;
        int          e_stall;
        int          e_req;
        int          e_rv;
        int          e_be;
        int          e_mis;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int e_stall, e_req, e_rv, e_be, e_mis;
        logic rd, wr;
        logic [31:0] a;
        int op, rdy;

        tbl[0] = '{"load_rdy3",    1'b1, 1'b0, 32'h100, 32'h0,        3,  32'hDEADBEEF, 4,  3,  1, 0, 0, 32'hDEADBEEF};
        tbl[1] = '{"store_rdy1",   1'b0, 1'b1, 32'h204, 32'h12345678, 1,  32'h0,        2,  1,  0, 0, 0, 32'hDEADBEEF};
        tbl[2] = '{"load_timeout", 1'b1, 1'b0, 32'h300, 32'h0,        0,  32'h0,        17, 16, 0, 1, 0, 32'h0};
        tbl[3] = '{"load_rdy_tc",  1'b1, 1'b0, 32'h400, 32'h0,        16, 32'hCAFEF00D, 17, 16, 1, 0, 0, 32'hCAFEF00D};
        tbl[4] = '{"store_tmo",    1'b0, 1'b1, 32'h480, 32'h0BADF00D, 0,  32'h0,        17, 16, 0, 1, 0, 32'hCAFEF00D};
        tbl[5] = '{"rw_as_write",  1'b1, 1'b1, 32'h508, 32'hA5A5A5A5, 2,  32'h77777777, 3,  2,  0, 0, 0, 32'hCAFEF00D};
        tbl[6] = '{"load_rdy1",    1'b1, 1'b0, 32'h010, 32'h0,        1,  32'h00000001, 2,  1,  1, 0, 0, 32'h00000001};
        if (MIS_EN)
            tbl[7] = '{"load_mis",  1'b1, 1'b0, 32'h102, 32'h0,       2,  32'h55AA55AA, 1,  0,  0, 0, 1, 32'h0};
        else
            tbl[7] = '{"load_x102", 1'b1, 1'b0, 32'h102, 32'h0,       2,  32'h55AA55AA, 3,  2,  1, 0, 0, 32'h55AA55AA};

        rst_n = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
        addr_m = 32'h0; wdata_m = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        model_rdata = 32'h0;
        #12;
        check("reset.dmem_req", 32'(dmem_req), 32'd0);
        check("reset.dmem_we", 32'(dmem_we), 32'd0);
        check("reset.dmem_addr", dmem_addr, 32'h0);
        check("reset.dmem_wdata", dmem_wdata, 32'h0);
        check("reset.rdata_m", rdata_m, 32'h0);
        check("reset.pulses", {29'h0, rdata_valid, bus_error, misalign}, 32'h0);
        check("reset.stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_and_check(tbl[i].tag, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdy,
                          tbl[i].rdata, tbl[i].e_stall, tbl[i].e_req, tbl[i].e_rv, tbl[i].e_be,
                          tbl[i].e_mis, tbl[i].e_rdata);
        end
        model_rdata = tbl[7].e_rdata;

        // Reset asserted while a load is outstanding.
        mem_read_m = 1'b1; addr_m = 32'h600; dmem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midreq.req_high", 32'(dmem_req), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0; mem_read_m = 1'b0;
        #1;
        check("midreq.req_dropped", 32'(dmem_req), 32'd0);
        check("midreq.stall_dropped", 32'(stall), 32'd0);
        check("midreq.no_report", {30'h0, rdata_valid, bus_error}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_rdata = 32'h0;
        @(negedge clk);
        run_and_check("after_reset", 1'b1, 1'b0, 32'h700, 32'h0, 2, 32'h0BADC0DE, 3, 2, 1, 0, 0, 32'h0BADC0DE);
        model_rdata = 32'h0BADC0DE;

        // Randomized accesses against the reference rules.
        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(0, 3);
            rd  = (op != 1);
            wr  = (op == 1) || (op == 3);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            rdy = $urandom_range(0, TIMEOUT + 1);
            begin
                logic [31:0] rdat;
                logic [31:0] wd;
                rdat = $urandom;
                wd   = $urandom;
                model(wr, a, rdy, rdat, model_rdata, e_stall, e_req, e_rv, e_be, e_mis);
                run_and_check($sformatf("rand%0d", i), rd, wr, a, wd, rdy, rdat,
                              e_stall, e_req, e_rv, e_be, e_mis, model_rdata);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
